// File: rtl/fp64_pkg.sv
// Shared constants and the stage-1 pipeline record for the FP64 normalize/round stage.
// Flag vectors are ordered {overflow, underflow, inexact, zero}.
package fp64_pkg;

    localparam int WIDTH    = 107;
    localparam int CNT_W    = 7;
    localparam int EXP_IN_W = 13;
    localparam int EXP_W    = 11;
    localparam int MAN_W    = 52;

    localparam int BIAS     = 1023;
    localparam int EXP_MAX  = 2047;

    localparam int OVF = 3;
    localparam int UNF = 2;
    localparam int INX = 1;
    localparam int ZRO = 0;

    // The normalized sum has its leading one at bit WIDTH-1, with the fraction directly below it.
    typedef struct packed {
        logic [WIDTH-1:0]          sh;
        logic signed [EXP_IN_W:0]  e;
        logic                      sign;
        logic                      invalid;
        logic                      special;
        logic [63:0]               special_val;
    } s1_reg_t;

endpackage

// File: rtl/fp_rne_round.sv
// Round-to-nearest-even on a 52-bit fraction, with exponent bump when the fraction wraps.
module fp_rne_round
    import fp64_pkg::*;
(
    input  logic [MAN_W-1:0]         frac,
    input  logic                     guard,
    input  logic                     sticky,
    input  logic signed [EXP_IN_W:0] e,
    output logic [MAN_W-1:0]         frac_rnd,
    output logic signed [EXP_IN_W:0] e_rnd,
    output logic                     inexact
);

    logic           round_up;
    logic [MAN_W:0] frac_sum;

    // Ties go up only when that makes the fraction even.
    assign round_up = guard & (sticky | frac[0]);
    assign frac_sum = {1'b0, frac} + {{MAN_W{1'b0}}, round_up};
    assign frac_rnd = frac_sum[MAN_W-1:0];
    assign e_rnd    = e + {{EXP_IN_W{1'b0}}, frac_sum[MAN_W]};
    assign inexact  = guard | sticky;

endmodule

// File: rtl/fp_norm_round.sv
// Two-stage normalize (with one-bit LZA correction) and RNE round/pack to binary64.
// Stage 1 left-normalizes the sum; stage 2 rounds, range-checks and selects the result.
module fp_norm_round
    import fp64_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_sum,
    input  logic                    in_sign,
    input  logic [EXP_IN_W-1:0]     in_exp,
    input  logic [CNT_W-1:0]        in_zero_cnt,
    input  logic                    in_invalid,
    input  logic                    in_special,
    input  logic [63:0]             in_special_val,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [63:0]             out_result,
    output logic [3:0]              out_flags
);

    localparam logic signed [EXP_IN_W:0] E_OVF  = (EXP_IN_W+1)'(EXP_MAX);
    localparam logic signed [EXP_IN_W:0] E_ZERO = '0;

    // Handshake: a beat moves on every edge where valid & ready. A stage loads when it is
    // empty or its contents leave this edge, so in_ready depends only on stage occupancy
    // and out_ready, never on in_valid.
    logic    s1_valid, s2_valid;
    logic    s1_adv, s2_adv;
    s1_reg_t s1_d, s1_q;

    assign s2_adv    = ~s2_valid | out_ready;
    assign s1_adv    = ~s1_valid | s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid;

    logic [WIDTH-1:0] sh0;
    logic [CNT_W:0]   lz;

    always_comb begin
        sh0 = in_sum << in_zero_cnt;
        s1_d = '0;
        // The anticipator may undershoot by one; a clear top bit means one more shift.
        if (sh0[WIDTH-1]) begin
            s1_d.sh = sh0;
            lz      = {1'b0, in_zero_cnt};
        end else begin
            s1_d.sh = sh0 << 1;
            lz      = {1'b0, in_zero_cnt} + {{CNT_W{1'b0}}, 1'b1};
        end
        s1_d.e = {in_exp[EXP_IN_W-1], in_exp} + (EXP_IN_W+1)'(1)
               - {{(EXP_IN_W-CNT_W){1'b0}}, lz};
        s1_d.sign        = in_sign;
        s1_d.invalid     = in_invalid;
        s1_d.special     = in_special;
        s1_d.special_val = in_special_val;
    end

    logic [MAN_W-1:0]         frac_rnd;
    logic signed [EXP_IN_W:0] e_rnd;
    logic                     inexact;

    fp_rne_round u_round (
        .frac     (s1_q.sh[WIDTH-2 -: MAN_W]),
        .guard    (s1_q.sh[WIDTH-2-MAN_W]),
        .sticky   (|s1_q.sh[WIDTH-3-MAN_W:0]),
        .e        (s1_q.e),
        .frac_rnd (frac_rnd),
        .e_rnd    (e_rnd),
        .inexact  (inexact)
    );

    logic [63:0] res_d;
    logic [3:0]  flg_d;

    always_comb begin
        res_d = '0;
        flg_d = '0;
        if (s1_q.special) begin
            res_d = s1_q.special_val;
        end else if (s1_q.invalid) begin
            flg_d[ZRO] = 1'b1;
        end else if (e_rnd >= E_OVF) begin
            res_d      = {s1_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flg_d[OVF] = 1'b1;
            flg_d[INX] = 1'b1;
        end else if (e_rnd <= E_ZERO) begin
            // No subnormal output: anything below the normal range flushes to signed zero.
            res_d      = {s1_q.sign, 63'd0};
            flg_d[UNF] = 1'b1;
            flg_d[ZRO] = 1'b1;
            flg_d[INX] = 1'b1;
        end else begin
            res_d      = {s1_q.sign, e_rnd[EXP_W-1:0], frac_rnd};
            flg_d[INX] = inexact;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid   <= 1'b0;
            s2_valid   <= 1'b0;
            s1_q       <= '0;
            out_result <= '0;
            out_flags  <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid <= in_valid;
                if (in_valid) s1_q <= s1_d;
            end
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    out_result <= res_d;
                    out_flags  <= flg_d;
                end
            end
        end
    end

endmodule
